lmsm_sequencer: RTL

- Sits between the ID/RR boundary and the RR_EX pipeline register, upstream of the EX control unit.
- Passes ordinary instructions through with one register stage.
- Expands each LM (opcode 0110) and SM (0111) into a stream of LW/SW micro-ops, one per set bit of the register list. The EX stage therefore only ever sees single-register memory operations.
- Drives the is_lm flag that EX uses for destination-mux selection.

---
 rtl/risc_pkg.sv | 38 +++
 rtl/lmsm_pick.sv | 43 ++++
 rtl/lmsm_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/risc_pkg.sv
// Shared opcodes, field widths and bundles for the LM/SM sequencer.
// Optional LMSM_BASE_DEFER_EN lives in the sequencer top.
package risc_pkg;

    localparam int OPC_W  = 4;
    localparam int REG_W  = 3;
    localparam int LIST_W = 8;
    localparam int IMM_W  = 6;

    localparam logic [OPC_W-1:0] OP_LW = 4'b0100;
    localparam logic [OPC_W-1:0] OP_SW = 4'b0101;
    localparam logic [OPC_W-1:0] OP_LM = 4'b0110;
    localparam logic [OPC_W-1:0] OP_SM = 4'b0111;

    localparam logic [15:0] NOP_IR = 16'hE000;

    typedef enum logic {IDLE, EXPAND} seq_state_e;

    typedef struct packed {
        logic        valid;
        logic [15:0] ir;
        logic [15:0] pc;
        logic        is_lm;
        logic        is_sm;
        logic        last;
    } seq_out_t;

    localparam seq_out_t OUT_RST = '{
        valid: 1'b0, ir: NOP_IR, pc: 16'h0000,
        is_lm: 1'b0, is_sm: 1'b0, last: 1'b0
    };

    // Register list bit 7 is R0, bit 0 is R7.
    function automatic logic [LIST_W-1:0] reg_bit(input logic [REG_W-1:0] r);
        return 8'h80 >> r;
    endfunction

endpackage

// File: rtl/lmsm_pick.sv
// Chooses the next register of an LM/SM list and its positional offset.
// Optional LMSM_BASE_DEFER_EN is applied by the caller via defer.
module lmsm_pick
    import risc_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic [LIST_W-1:0] mask,
    input  logic [LIST_W-1:0] orig_mask,
    input  logic [REG_W-1:0]  base,
    input  logic              defer,
    output logic [REG_W-1:0]  idx,
    output logic [IMM_W-1:0]  imm,
    output logic              last
);

    logic [LIST_W-1:0] bmask;
    logic [LIST_W-1:0] cand;
    logic              found;

    always_comb begin
        bmask = reg_bit(base);
        cand  = mask;
        // Hold back the base register while any other register remains.
        if (defer && ((mask & bmask) != '0) && ((mask & ~bmask) != '0))
            cand = mask & ~bmask;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < LIST_W; i++) begin
            if (!found && cand[LIST_W-1-i]) begin
                idx   = REG_W'(i);
                found = 1'b1;
            end
        end
        imm = '0;
        for (int i = 0; i < LIST_W; i++) begin
            if ((i < int'(idx)) && orig_mask[LIST_W-1-i])
                imm = imm + IMM_W'(1);
        end
        last = ($countones(mask) == 1);
    end

endmodule

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM into LW/SW micro-ops; passes other instructions through.
// Define LMSM_BASE_DEFER_EN to emit an LM's in-list base register last.
module lmsm_sequencer
    import risc_pkg::*;
#(
    parameter int IMM_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_ir,
    input  logic [15:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ir,
    output logic [15:0] out_pc,
    output logic        out_is_lm,
    output logic        out_is_sm,
    output logic        out_last,
    output logic        busy
);

    seq_state_e        state, state_d;
    logic [LIST_W-1:0] mask, mask_d;
    logic [LIST_W-1:0] orig, orig_d;
    logic [REG_W-1:0]  base, base_d;
    logic              is_sm, is_sm_d;
    seq_out_t          out_q, out_d;

    logic              idle, advance, accept, in_lmsm;
    logic [LIST_W-1:0] p_mask, p_orig;
    logic [REG_W-1:0]  p_base, p_idx;
    logic              p_sm, p_defer, p_last;
    logic [IMM_W-1:0]  p_imm;
    logic [15:0]       uop;

    assign idle     = (state == IDLE);
    assign advance  = !out_q.valid || out_ready;
    assign in_ready = idle && advance && !flush;
    assign accept   = in_valid && in_ready;
    assign in_lmsm  = (in_ir[15:12] == OP_LM) || (in_ir[15:12] == OP_SM);

    // In IDLE the first micro-op is picked straight from the incoming word.
    assign p_mask = idle ? in_ir[7:0] : mask;
    assign p_orig = idle ? in_ir[7:0] : orig;
    assign p_base = idle ? in_ir[11:9] : base;
    assign p_sm   = idle ? (in_ir[15:12] == OP_SM) : is_sm;

`ifdef LMSM_BASE_DEFER_EN
    assign p_defer = !p_sm;
`else
    assign p_defer = 1'b0;
`endif

    lmsm_pick #(.IMM_W(IMM_W)) u_pick (
        .mask      (p_mask),
        .orig_mask (p_orig),
        .base      (p_base),
        .defer     (p_defer),
        .idx       (p_idx),
        .imm       (p_imm),
        .last      (p_last)
    );

    assign uop = {(p_sm ? OP_SW : OP_LW), p_idx, p_base, p_imm};

    always_comb begin
        state_d = state;
        mask_d  = mask;
        orig_d  = orig;
        base_d  = base;
        is_sm_d = is_sm;
        out_d   = out_q;
        if (flush) begin
            out_d.valid = 1'b0;
            state_d     = IDLE;
            mask_d      = '0;
        end else if (advance) begin
            unique case (1'b1)
                !idle: begin
                    out_d.valid = 1'b1;
                    out_d.ir    = uop;
                    out_d.last  = p_last;
                    mask_d      = mask & ~reg_bit(p_idx);
                    state_d     = p_last ? IDLE : EXPAND;
                end
                accept && in_lmsm: begin
                    orig_d      = in_ir[7:0];
                    base_d      = in_ir[11:9];
                    is_sm_d     = p_sm;
                    out_d.valid = 1'b1;
                    out_d.pc    = in_pc;
                    out_d.is_lm = !p_sm;
                    out_d.is_sm = p_sm;
                    if (in_ir[7:0] == '0) begin
                        out_d.ir   = NOP_IR;
                        out_d.last = 1'b1;
                        mask_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        out_d.ir   = uop;
                        out_d.last = p_last;
                        mask_d     = in_ir[7:0] & ~reg_bit(p_idx);
                        state_d    = p_last ? IDLE : EXPAND;
                    end
                end
                accept && !in_lmsm: begin
                    out_d = '{valid: 1'b1, ir: in_ir, pc: in_pc,
                              is_lm: 1'b0, is_sm: 1'b0, last: 1'b1};
                end
                default: out_d.valid = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mask  <= '0;
            orig  <= '0;
            base  <= '0;
            is_sm <= 1'b0;
            out_q <= OUT_RST;
        end else begin
            state <= state_d;
            mask  <= mask_d;
            orig  <= orig_d;
            base  <= base_d;
            is_sm <= is_sm_d;
            out_q <= out_d;
        end
    end

    assign out_valid = out_q.valid;
    assign out_ir    = out_q.ir;
    assign out_pc    = out_q.pc;
    assign out_is_lm = out_q.is_lm;
    assign out_is_sm = out_q.is_sm;
    assign out_last  = out_q.last;
    assign busy      = (state == EXPAND);

endmodule
